vdp_host_port: RTL and testbench
================================

// Module: vdp_host_port
// PURPOSE
//  Parametrised TMS9918A/V9938-style host bus interface for the VDP cores: decodes the
//  two-port (data/control) 8-bit host protocol, holds the VRAM address pointer with extended
//  bank bits, drives a req/ack VRAM port with read-ahead, emits register writes with F18A-style
//  lock/unlock filtering, and generates the frame interrupt. Sits between the host bus glue and VDP core.
// PARAMETERS
//  VADDR_W     14     VRAM address width, 14..18; bits above 13 come from register 14
//  REG_ADDR_W  6      register index width (3 = classic 9918A, 6 = 64 extended regs)
//  LOCKED_BASE 8      register indices >= this are dropped while locked
//  UNLOCK_REG  57     register used for the unlock sequence (always writable)
//  UNLOCK_KEY  8'h1C  key value for the unlock sequence
// PORTS
//  clk_logic_i    in   1        logic clock, all state on rising edge
//  reset_n_i      in   1        asynchronous active-low reset
//  mode_i         in   1        0 = data port, 1 = control port; sampled on strobe falling edge
//  csw_n_i        in   1        write strobe, active low, synchronous to clk_logic_i
//  csr_n_i        in   1        read strobe, active low, synchronous to clk_logic_i
//  cd_i           in   8        host write data, sampled on csw_n_i falling edge
//  cd_o           out  8        host read data (registered)
//  int_n_o        out  1        frame interrupt, active low
//  vblank_i       in   1        one-cycle pulse at start of vertical blank
//  status_i       in   7        status bits 6:0 {5S, C, fifth-sprite[4:0]} from the core
//  vram_req_o     out  1        VRAM transaction request, held until ack
//  vram_we_o      out  1        1 = write, 0 = read; stable while req
//  vram_addr_o    out  VADDR_W  VRAM address; stable while req
//  vram_wdata_o   out  8        VRAM write data; stable while req
//  vram_ack_i     in   1        transaction complete (read data valid this cycle)
//  vram_rdata_i   in   8        VRAM read data
//  reg_we_o       out  1        one-cycle register write pulse
//  reg_addr_o     out  REG_ADDR_W register index
//  reg_data_o     out  8        register data
//  unlocked_o     out  1        extended registers unlocked
//  ovr_cnt_o      out  8        saturating count of dropped data-port accesses
// BEHAVIOUR
//  Reset: cd_o=0, int_n_o=1, vram_req_o/we_o=0, addr/wdata=0, reg_we_o=0, unlocked_o=0,
//   ovr_cnt_o=0; internal pointer, R14 bank, IE, F flag, byte latch, read buffer, key state cleared.
//   Reset mid-transaction drops req immediately; late ack ignored.
//  Edge detect: strobe event = strobe high previous cycle, low this cycle. Both falling same
//   cycle: read serviced, write ignored. Actions take effect the cycle after the edge.
//  Control write, latch empty: store cd_i as first byte, set latch. Latch full: clear latch; then
//   cd_i[7]=1: register write, index=cd_i[REG_ADDR_W-1:0], data=first byte;
//   cd_i[7]=0: pointer[13:0]={cd_i[5:0],first}; cd_i[6]=0 (read setup) issues prefetch read.
//  Register write: if index>=LOCKED_BASE && !unlocked && index!=UNLOCK_REG -> dropped (no pulse).
//   Else reg_we_o pulses 1 cycle. Shadow: R1 bit5 = IE; R14 low (VADDR_W-14) bits = bank.
//   Unlock: two consecutive writes of UNLOCK_KEY to UNLOCK_REG -> unlocked_o=1; any other value
//   to UNLOCK_REG resets the sequence; writing 8'h00 to UNLOCK_REG while unlocked relocks.
//  Any data-port access or status read clears the byte latch.
//  VRAM addr = {bank, pointer[13:0]}. Pointer+bank form one VADDR_W counter incremented at issue
//   of each data write/prefetch; wraps all-ones -> 0; carry updates bank shadow (no reg_we_o).
//  FSM: IDLE -> REQ on issue (req=1, addr/we/wdata loaded); REQ -> IDLE cycle after vram_ack_i.
//   Read ack: vram_rdata_i -> read buffer. Data write issues write of cd_i.
//  Data read: cd_o <= read buffer, then prefetch read issued. Data access while REQ -> dropped,
//   pointer unchanged, ovr_cnt_o+1 saturating at 255. Control-port accesses never blocked.
//  Status read (control port): cd_o <= {F, status_i}; F cleared, int_n_o deasserts next cycle.
//  vblank_i sets F; int_n_o = !(F & IE). vblank coincident with status read: F stays set.
//  Host holds csr_n_i low >= 2 cycles for cd_o to be valid.
// TESTING
//  Ctrl writes 0x34,0x52 -> pointer 0x1234, write setup, no req; data write 0xAA -> req,we=1,
//   addr 0x1234, data 0xAA; ack -> next write addr 0x1235.
//  Ctrl 0x00,0x00 (read setup) -> read req addr 0; ack rdata 0x5C; data read -> cd_o=0x5C, new req addr 1.
//  Ctrl 0xE0,0x81 -> reg_we_o 1 cycle, addr 1, data 0xE0; vblank pulse -> int_n_o=0; status read
//   -> cd_o[7]=1, int_n_o=1 next cycle.
//  Locked: write 0x07 to reg 40 -> no pulse; 0x1C,0x1C to reg 57 -> unlocked_o=1; reg 40 write pulses.
//  VADDR_W=17: R14=0x03, pointer 0x3FFF, data write -> addr 0x0FFFF then next 0x10000; at 0x1FFFF wraps to 0.
//  Data write while REQ pending -> no new req, ovr_cnt_o 0->1; reset asserted during REQ -> req=0 async.

Source files
------------

// File: rtl/vdp_host_port.sv
// Host bus front end for the VDP: two-port 8-bit protocol decode, VRAM pointer with bank bits,
// req/ack VRAM port with read-ahead, filtered register writes and the frame interrupt.
module vdp_host_port #(
  parameter int         VADDR_W     = 14,
  parameter int         REG_ADDR_W  = 6,
  parameter int         LOCKED_BASE = 8,
  parameter int         UNLOCK_REG  = 57,
  parameter logic [7:0] UNLOCK_KEY  = 8'h1C
) (
  input  logic                  clk_logic_i,
  input  logic                  reset_n_i,
  input  logic                  mode_i,
  input  logic                  csw_n_i,
  input  logic                  csr_n_i,
  input  logic [7:0]            cd_i,
  output logic [7:0]            cd_o,
  output logic                  int_n_o,
  input  logic                  vblank_i,
  input  logic [6:0]            status_i,
  output logic                  vram_req_o,
  output logic                  vram_we_o,
  output logic [VADDR_W-1:0]    vram_addr_o,
  output logic [7:0]            vram_wdata_o,
  input  logic                  vram_ack_i,
  input  logic [7:0]            vram_rdata_i,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] reg_addr_o,
  output logic [7:0]            reg_data_o,
  output logic                  unlocked_o,
  output logic [7:0]            ovr_cnt_o
);

  localparam int          BANK_W = VADDR_W - 14;
  localparam logic [31:0] LOCK_B = LOCKED_BASE;
  localparam logic [31:0] UNL_R  = UNLOCK_REG;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state_reg;
  logic                csw_q_reg;
  logic                csr_q_reg;
  logic                latch_reg;
  logic [7:0]          first_reg;
  logic [VADDR_W-1:0]  vptr_reg;
  logic                ie_reg;
  logic                f_reg;
  logic [7:0]          rbuf_reg;
  logic                key_seen_reg;
  logic                pend_reg;

  logic                rd_ev;
  logic                wr_ev;
  logic                data_wr;
  logic                data_rd;
  logic                ctrl_wr;
  logic                stat_rd;
  logic                busy;
  logic                drop;
  logic                second;
  logic                reg_cmd;
  logic                ptr_cmd;
  logic                rd_setup;
  logic                pend_go;
  logic                issue;
  logic                issue_we;
  logic [VADDR_W-1:0]  issue_addr;
  logic [VADDR_W-1:0]  ptr_load;
  logic [VADDR_W-1:0]  vptr_bank;
  logic [REG_ADDR_W-1:0] reg_idx;
  logic [31:0]         idx_ext;
  logic                reg_ok;
  logic                is_r1;
  logic                is_r14;
  logic                is_unl;

  // A simultaneous read strobe wins; the write edge on that cycle is discarded.
  always_comb begin
    rd_ev   = csr_q_reg & ~csr_n_i;
    wr_ev   = csw_q_reg & ~csw_n_i & ~rd_ev;
    data_wr = wr_ev & ~mode_i;
    ctrl_wr = wr_ev & mode_i;
    data_rd = rd_ev & ~mode_i;
    stat_rd = rd_ev & mode_i;
    busy    = (state_reg == S_REQ) | pend_reg;
    drop    = (data_wr | data_rd) & busy;
    second  = ctrl_wr & latch_reg;
    reg_cmd = second & cd_i[7];
    ptr_cmd = second & ~cd_i[7];
    rd_setup = ptr_cmd & ~cd_i[6];
    pend_go = (state_reg == S_IDLE) & pend_reg & ~wr_ev & ~rd_ev;
  end

  always_comb begin
    reg_idx = cd_i[REG_ADDR_W-1:0];
    idx_ext = {{(32-REG_ADDR_W){1'b0}}, reg_idx};
    is_r1   = (idx_ext == 32'd1);
    is_r14  = (idx_ext == 32'd14);
    is_unl  = (idx_ext == UNL_R);
    reg_ok  = !((idx_ext >= LOCK_B) && !unlocked_o && !is_unl);
  end

  always_comb begin
    ptr_load        = vptr_reg;
    ptr_load[13:0]  = {cd_i[5:0], first_reg};
  end

  // Bank bits live in the top of the pointer so carries ripple into them for free.
  generate
    if (BANK_W > 0) begin : g_bank
      always_comb begin
        vptr_bank                 = vptr_reg;
        vptr_bank[VADDR_W-1:14]   = first_reg[BANK_W-1:0];
      end
    end else begin : g_nobank
      assign vptr_bank = vptr_reg;
    end
  endgenerate

  always_comb begin
    issue      = 1'b0;
    issue_we   = 1'b0;
    issue_addr = vptr_reg;
    if (data_wr && !busy) begin
      issue    = 1'b1;
      issue_we = 1'b1;
    end else if (data_rd && !busy) begin
      issue = 1'b1;
    end else if (rd_setup && !busy) begin
      issue      = 1'b1;
      issue_addr = ptr_load;
    end else if (pend_go) begin
      issue = 1'b1;
    end
  end

  assign int_n_o = ~(f_reg & ie_reg);

  always_ff @(posedge clk_logic_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg    <= S_IDLE;
      csw_q_reg    <= 1'b1;
      csr_q_reg    <= 1'b1;
      latch_reg    <= 1'b0;
      first_reg    <= 8'h00;
      vptr_reg     <= '0;
      ie_reg       <= 1'b0;
      f_reg        <= 1'b0;
      rbuf_reg     <= 8'h00;
      key_seen_reg <= 1'b0;
      pend_reg     <= 1'b0;
      cd_o         <= 8'h00;
      vram_req_o   <= 1'b0;
      vram_we_o    <= 1'b0;
      vram_addr_o  <= '0;
      vram_wdata_o <= 8'h00;
      reg_we_o     <= 1'b0;
      reg_addr_o   <= '0;
      reg_data_o   <= 8'h00;
      unlocked_o   <= 1'b0;
      ovr_cnt_o    <= 8'h00;
    end else begin
      csw_q_reg <= csw_n_i;
      csr_q_reg <= csr_n_i;
      reg_we_o  <= 1'b0;

      if (data_wr || data_rd || stat_rd) begin
        latch_reg <= 1'b0;
      end else if (ctrl_wr) begin
        if (latch_reg) begin
          latch_reg <= 1'b0;
        end else begin
          latch_reg <= 1'b1;
          first_reg <= cd_i;
        end
      end

      if (issue) begin
        vptr_reg <= issue_addr + VADDR_W'(1);
      end else if (ptr_cmd) begin
        vptr_reg <= ptr_load;
      end else if (reg_cmd && reg_ok && is_r14) begin
        vptr_reg <= vptr_bank;
      end

      if (pend_go) begin
        pend_reg <= 1'b0;
      end else if (rd_setup && busy) begin
        pend_reg <= 1'b1;
      end

      if (reg_cmd) begin
        reg_we_o   <= reg_ok;
        reg_addr_o <= reg_idx;
        reg_data_o <= first_reg;
        if (reg_ok && is_r1) begin
          ie_reg <= first_reg[5];
        end
        if (is_unl) begin
          if (unlocked_o && first_reg == 8'h00) begin
            unlocked_o   <= 1'b0;
            key_seen_reg <= 1'b0;
          end else if (first_reg == UNLOCK_KEY) begin
            if (key_seen_reg) begin
              unlocked_o   <= 1'b1;
              key_seen_reg <= 1'b0;
            end else begin
              key_seen_reg <= 1'b1;
            end
          end else begin
            key_seen_reg <= 1'b0;
          end
        end
      end

      // A vblank landing on the same cycle as the status read must not be lost.
      if (vblank_i) begin
        f_reg <= 1'b1;
      end else if (stat_rd) begin
        f_reg <= 1'b0;
      end

      if (stat_rd) begin
        cd_o <= {f_reg, status_i};
      end else if (data_rd && !busy) begin
        cd_o <= rbuf_reg;
      end

      if (drop && ovr_cnt_o != 8'hFF) begin
        ovr_cnt_o <= ovr_cnt_o + 8'd1;
      end

      case (state_reg)
        S_IDLE: begin
          if (issue) begin
            state_reg   <= S_REQ;
            vram_req_o  <= 1'b1;
            vram_we_o   <= issue_we;
            vram_addr_o <= issue_addr;
            if (issue_we) begin
              vram_wdata_o <= cd_i;
            end
          end
        end
        S_REQ: begin
          if (vram_ack_i) begin
            state_reg  <= S_IDLE;
            vram_req_o <= 1'b0;
            vram_we_o  <= 1'b0;
            if (!vram_we_o) begin
              rbuf_reg <= vram_rdata_i;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_host_port.sv
// Directed bench for vdp_host_port with a 17-bit VRAM address: protocol, read-ahead,
// register lock filtering, interrupt, bank carry/wrap, overrun and async reset.
module tb_vdp_host_port;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        csw_n;
  logic        csr_n;
  logic [7:0]  cd_in;
  logic [7:0]  cd_out;
  logic        int_n;
  logic        vblank;
  logic [6:0]  status;
  logic        vram_req;
  logic        vram_we;
  logic [16:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack;
  logic [7:0]  vram_rdata;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        unlocked;
  logic [7:0]  ovr_cnt;

  int n_vec = 0;
  int n_err = 0;

  vdp_host_port #(.VADDR_W(17)) dut (
    .clk_logic_i (clk),
    .reset_n_i   (rst_n),
    .mode_i      (mode),
    .csw_n_i     (csw_n),
    .csr_n_i     (csr_n),
    .cd_i        (cd_in),
    .cd_o        (cd_out),
    .int_n_o     (int_n),
    .vblank_i    (vblank),
    .status_i    (status),
    .vram_req_o  (vram_req),
    .vram_we_o   (vram_we),
    .vram_addr_o (vram_addr),
    .vram_wdata_o(vram_wdata),
    .vram_ack_i  (vram_ack),
    .vram_rdata_i(vram_rdata),
    .reg_we_o    (reg_we),
    .reg_addr_o  (reg_addr),
    .reg_data_o  (reg_data),
    .unlocked_o  (unlocked),
    .ovr_cnt_o   (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic m, input logic [7:0] d);
    @(posedge clk); #1;
    mode = m; cd_in = d; csw_n = 1'b0;
    @(posedge clk); #1;
    csw_n = 1'b1;
  endtask

  task automatic rd(input logic m, output logic [7:0] d, output logic irq_n);
    @(posedge clk); #1;
    mode = m; csr_n = 1'b0;
    @(posedge clk); #1;
    d = cd_out; irq_n = int_n;
    @(posedge clk); #1;
    csr_n = 1'b1;
  endtask

  task automatic ack(input logic [7:0] d);
    @(posedge clk); #1;
    vram_ack = 1'b1; vram_rdata = d;
    @(posedge clk); #1;
    vram_ack = 1'b0;
  endtask

  logic [7:0] rdv;
  logic       irqv;

  initial begin
    rst_n = 1'b0; mode = 1'b0; csw_n = 1'b1; csr_n = 1'b1; cd_in = 8'h00;
    vblank = 1'b0; status = 7'h00; vram_ack = 1'b0; vram_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cd", cd_out, 8'h00);
    check("rst_int_n", int_n, 1'b1);
    check("rst_req", vram_req, 1'b0);
    check("rst_we", vram_we, 1'b0);
    check("rst_addr", vram_addr, 17'h0);
    check("rst_wdata", vram_wdata, 8'h00);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_ovr", ovr_cnt, 8'h00);
    rst_n = 1'b1;

    // write setup to 0x1234, then two data writes
    wr(1'b1, 8'h34); wr(1'b1, 8'h52);
    check("wsetup_noreq", vram_req, 1'b0);
    wr(1'b0, 8'hAA);
    check("dw1_req", vram_req, 1'b1);
    check("dw1_we", vram_we, 1'b1);
    check("dw1_addr", vram_addr, 17'h01234);
    check("dw1_data", vram_wdata, 8'hAA);
    ack(8'h00);
    check("dw1_ackdone", vram_req, 1'b0);
    wr(1'b0, 8'hBB);
    check("dw2_addr", vram_addr, 17'h01235);
    check("dw2_data", vram_wdata, 8'hBB);
    ack(8'h00);

    // read setup at 0 with prefetch, then data read
    wr(1'b1, 8'h00); wr(1'b1, 8'h00);
    check("rsetup_req", vram_req, 1'b1);
    check("rsetup_we", vram_we, 1'b0);
    check("rsetup_addr", vram_addr, 17'h00000);
    ack(8'h5C);
    check("rsetup_done", vram_req, 1'b0);
    rd(1'b0, rdv, irqv);
    check("dr_cd", rdv, 8'h5C);
    check("dr_req", vram_req, 1'b1);
    check("dr_addr", vram_addr, 17'h00001);
    ack(8'h11);

    // R1 = 0xE0 enables the interrupt
    wr(1'b1, 8'hE0); wr(1'b1, 8'h81);
    check("r1_we", reg_we, 1'b1);
    check("r1_addr", reg_addr, 6'd1);
    check("r1_data", reg_data, 8'hE0);
    @(posedge clk); #1;
    check("r1_pulse_end", reg_we, 1'b0);
    check("int_idle", int_n, 1'b1);
    vblank = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b0;
    check("int_vblank", int_n, 1'b0);
    status = 7'h25;
    rd(1'b1, rdv, irqv);
    check("stat1_cd", rdv, 8'hA5);
    check("stat1_int_n", irqv, 1'b1);
    rd(1'b1, rdv, irqv);
    check("stat2_cd", rdv, 8'h25);

    // lock filtering and unlock sequence
    wr(1'b1, 8'h07); wr(1'b1, 8'hA8);
    check("locked_r40", reg_we, 1'b0);
    wr(1'b1, 8'h1C); wr(1'b1, 8'hB9);
    check("unl_r57_we", reg_we, 1'b1);
    check("unl_step1", unlocked, 1'b0);
    wr(1'b1, 8'h05); wr(1'b1, 8'hB9);
    wr(1'b1, 8'h1C); wr(1'b1, 8'hB9);
    check("unl_broken", unlocked, 1'b0);
    wr(1'b1, 8'h1C); wr(1'b1, 8'hB9);
    check("unl_done", unlocked, 1'b1);
    wr(1'b1, 8'h07); wr(1'b1, 8'hA8);
    check("r40_we", reg_we, 1'b1);
    check("r40_addr", reg_addr, 6'd40);
    check("r40_data", reg_data, 8'h07);

    // bank bits from R14 and carry / wrap of the 17-bit pointer
    wr(1'b1, 8'h03); wr(1'b1, 8'h8E);
    check("r14_we", reg_we, 1'b1);
    wr(1'b1, 8'hFF); wr(1'b1, 8'h7F);
    wr(1'b0, 8'h11);
    check("bank_addr_a", vram_addr, 17'h0FFFF);
    ack(8'h00);
    wr(1'b0, 8'h22);
    check("bank_carry", vram_addr, 17'h10000);
    ack(8'h00);
    wr(1'b1, 8'h07); wr(1'b1, 8'h8E);
    wr(1'b1, 8'hFF); wr(1'b1, 8'h7F);
    wr(1'b0, 8'h33);
    check("top_addr", vram_addr, 17'h1FFFF);
    ack(8'h00);
    wr(1'b0, 8'h44);
    check("wrap_addr", vram_addr, 17'h00000);
    ack(8'h00);

    // overrun while a request is outstanding; control port still works
    wr(1'b0, 8'h55);
    check("ovr_first_addr", vram_addr, 17'h00001);
    wr(1'b0, 8'h66);
    check("ovr_req_held", vram_req, 1'b1);
    check("ovr_addr_held", vram_addr, 17'h00001);
    check("ovr_data_held", vram_wdata, 8'h55);
    check("ovr_cnt", ovr_cnt, 8'd1);
    wr(1'b1, 8'h00); wr(1'b1, 8'hB9);
    check("relock", unlocked, 1'b0);

    // asynchronous reset mid-request, late ack ignored
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_req", vram_req, 1'b0);
    check("async_ovr", ovr_cnt, 8'd0);
    #1 rst_n = 1'b1;
    ack(8'h99);
    check("late_ack_req", vram_req, 1'b0);
    wr(1'b0, 8'h77);
    check("post_rst_addr", vram_addr, 17'h00000);
    check("post_rst_data", vram_wdata, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
